img_xfer_ctrl: RTL and testbench

Parametrised raster-scan transfer controller that moves an IMG_W x IMG_H frame from the input memory to the output memory. It generates input-memory reads and output-memory writes and has no data path of its own. Read-to-write spacing matches a configurable memory read latency. Adds a start/busy/done handshake, a stall input and an optional horizontal-mirror mode; sits between the top-level sequencer and the two frame memories.

---
 rtl/img_xfer_ctrl.sv | 157 +++++++++++++++
 tb/tb_img_xfer_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/img_xfer_ctrl.sv
// Raster-scan frame transfer controller: issues input-memory reads and delayed output-memory writes.
// Define MIRROR_EN to honour the mode input (horizontal-mirror destination addressing).
module img_xfer_ctrl #(
  parameter int unsigned IMG_W  = 800,
  parameter int unsigned IMG_H  = 600,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic              mode,
  output logic              en_in_mem,
  output logic [ADDR_W-1:0] in_mem_addr,
  output logic              en_out_mem,
  output logic              out_mem_write,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] XMax = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMax = YW'(IMG_H - 1);
  localparam longint unsigned NPix = longint'(IMG_W) * longint'(IMG_H);

  if (ADDR_W < 64) begin : g_addr_chk
    if (NPix >= (64'd1 << ADDR_W)) begin : g_frame_too_big
      $error("img_xfer_ctrl: IMG_W*IMG_H does not fit in ADDR_W bits");
    end
  end

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [ADDR_W-1:0]   row_base_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [RD_LAT-1:0]   dl_vld_q;
  logic [ADDR_W-1:0]   dl_addr_q [RD_LAT];

  logic                issue;
  logic                last_px;
  logic [ADDR_W-1:0]   src_addr;
  logic [ADDR_W-1:0]   dst_addr;
  logic [RD_LAT-1:0]   vld_d;

`ifdef MIRROR_EN
  logic mode_q;
  logic mirror_sel;
  // On the start edge the mode input itself applies; afterwards the latched copy.
  assign mirror_sel = (state_q == StRun) ? mode_q : mode;
  assign dst_addr   = mirror_sel ? (row_base_q + ADDR_W'(IMG_W - 1) - ADDR_W'(x_q)) : src_addr;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign dst_addr    = src_addr;
`endif

  assign src_addr      = row_base_q + ADDR_W'(x_q);
  assign last_px       = (x_q == XMax) && (y_q == YMax);
  assign en_out_mem    = dl_vld_q[RD_LAT-1];
  assign out_mem_write = dl_vld_q[RD_LAT-1];
  assign out_mem_addr  = dl_addr_q[RD_LAT-1];

  always_comb begin
    issue = 1'b0;
    unique case (state_q)
      StIdle, StDone: issue = start;
      StRun:          issue = ~hold;
      default:        issue = 1'b0;
    endcase
  end

  // Valid bits after the next edge; the read strobe itself feeds stage 0.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = en_in_mem;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i] = dl_vld_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      row_base_q  <= '0;
      dst_q       <= '0;
      en_in_mem   <= 1'b0;
      in_mem_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dl_vld_q    <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        dl_addr_q[i] <= '0;
      end
`ifdef MIRROR_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      // Addresses only advance with valid entries so the output address holds in bubbles.
      dl_vld_q <= vld_d;
      if (en_in_mem) dl_addr_q[0] <= dst_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        if (dl_vld_q[i-1]) dl_addr_q[i] <= dl_addr_q[i-1];
      end

      en_in_mem <= issue;
      if (issue) begin
        in_mem_addr <= src_addr;
        dst_q       <= dst_addr;
        if (x_q == XMax) begin
          x_q <= '0;
          if (y_q == YMax) begin
            y_q        <= '0;
            row_base_q <= '0;
          end else begin
            y_q        <= y_q + 1'b1;
            row_base_q <= row_base_q + ADDR_W'(IMG_W);
          end
        end else begin
          x_q <= x_q + 1'b1;
        end
      end

      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StRun;
            busy    <= 1'b1;
            done    <= 1'b0;
`ifdef MIRROR_EN
            mode_q  <= mode;
`endif
          end
        end
        StRun: begin
          if (issue && last_px) state_q <= StDrain;
        end
        StDrain: begin
          if (vld_d == '0) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_img_xfer_ctrl.sv
// Directed bench for img_xfer_ctrl (4x3 frame, read latency 2); builds with or without MIRROR_EN.
module tb_img_xfer_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned L  = 2;
  localparam int          N  = W * H;
`ifdef MIRROR_EN
  localparam bit MirrorOn = 1'b1;
`else
  localparam bit MirrorOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          hold;
  logic          mode;
  logic          en_in_mem;
  logic [AW-1:0] in_mem_addr;
  logic          en_out_mem;
  logic          out_mem_write;
  logic [AW-1:0] out_mem_addr;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;
  int prev_rd = 0;
  int prev_wr = 0;

  img_xfer_ctrl #(
    .IMG_W  (W),
    .IMG_H  (H),
    .ADDR_W (AW),
    .RD_LAT (L)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .hold          (hold),
    .mode          (mode),
    .en_in_mem     (en_in_mem),
    .in_mem_addr   (in_mem_addr),
    .en_out_mem    (en_out_mem),
    .out_mem_write (out_mem_write),
    .out_mem_addr  (out_mem_addr),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " ctl"}, 64'({en_in_mem, en_out_mem, out_mem_write, busy, done}), 64'd0);
    check({tag, " rd_addr"}, 64'(in_mem_addr), 64'd0);
    check({tag, " wr_addr"}, 64'(out_mem_addr), 64'd0);
  endtask

  function automatic int mir(input int p);
    return (p / W) * W + (W - 1) - (p % W);
  endfunction

  // hold is driven high in cycles hold_lo..hold_hi; start re-pulsed in cycle start_cyc (0 = never).
  task automatic run_xfer(input string name, input bit mode_v, input int hold_lo,
                          input int hold_hi, input int start_cyc, input int ncyc);
    bit rd_en [64];
    bit wr_en [64];
    int rd_a  [64];
    int wr_a  [64];
    int pix;
    int last_rd;
    bit mir_on;
    bit busy_e;
    bit done_e;
    mir_on  = mode_v && MirrorOn;
    pix     = 0;
    last_rd = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (pix < N && (c == 1 || !(c - 1 >= hold_lo && c - 1 <= hold_hi))) begin
        rd_en[c]   = 1'b1;
        rd_a[c]    = pix;
        wr_en[c+L] = 1'b1;
        wr_a[c+L]  = mir_on ? mir(pix) : pix;
        last_rd    = c;
        pix++;
      end
    end
    start = 1'b1;
    mode  = mode_v;
    hold  = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = (c == start_cyc);
      mode  = ~mode_v;
      hold  = (c >= hold_lo && c <= hold_hi);
      if (rd_en[c]) prev_rd = rd_a[c];
      if (wr_en[c]) prev_wr = wr_a[c];
      busy_e = (c <= last_rd + int'(L));
      done_e = (c > last_rd + int'(L));
      check($sformatf("%s c%0d ctl", name, c),
            64'({en_in_mem, en_out_mem, out_mem_write, busy, done}),
            64'({rd_en[c], wr_en[c], wr_en[c], busy_e, done_e}));
      check($sformatf("%s c%0d rd_addr", name, c), 64'(in_mem_addr), 64'(prev_rd));
      check($sformatf("%s c%0d wr_addr", name, c), 64'(out_mem_addr), 64'(prev_wr));
    end
    start = 1'b0;
    hold  = 1'b0;
    mode  = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    mode  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_zero("in_reset");
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_zero("idle");
    end

    run_xfer("copy", 1'b0, 0, -1, 0, 20);
    run_xfer("mirror", 1'b1, 0, -1, 0, 20);
    run_xfer("hold", 1'b0, 6, 8, 0, 22);
    run_xfer("start_in_run", 1'b0, 0, -1, 5, 20);
    run_xfer("restart", 1'b0, 0, -1, 0, 20);

    // Abort mid-transfer with an asynchronous reset in cycle 7.
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    check_zero("abort");
    prev_rd = 0;
    prev_wr = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_zero("post_abort");
    end
    run_xfer("after_abort", 1'b0, 0, -1, 0, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
